// File: rtl/receptor_display_serial.sv
// Serial display-frame receiver: resynchronises the line, deframes
// start/Sel/a..g/parity/stop, decodes the 7-segment glyph and holds the last
// good glyph and status code for the Caixa and TipoRega channels.
// Handshake: none; the line is free-running and QuadroOk, ErroParidade and
// ErroQuadro are single-cycle pulses with no back-pressure.
module receptor_display_serial #(
    parameter int CLKS_POR_BIT = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       LinhaSerial,
    output logic [6:0] SegCaixa,
    output logic [6:0] SegRega,
    output logic [1:0] NivelCaixa,
    output logic       NivelValido,
    output logic [1:0] TipoRega,
    output logic       RegaValido,
    output logic       QuadroOk,
    output logic       ErroParidade,
    output logic       ErroQuadro,
    output logic [1:0] EstadoFsm
);

    localparam int CW = $clog2(CLKS_POR_BIT) + 1;
    localparam logic [CW-1:0] MEIO = CW'(CLKS_POR_BIT / 2);
    localparam logic [CW-1:0] FIM  = CW'(CLKS_POR_BIT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DADOS = 2'd2, STOP = 2'd3} estado_t;

    estado_t       estado, estadoProx;
    logic          sinc1, sinc2, linhaAnt;
    logic [CW-1:0] clkCnt;
    logic [3:0]    bitIdx;
    logic [8:0]    quadro;
    logic          inicioPendente;
    logic          zeraCnt, amostra, fimQuadro;
    logic          bordaDescida;
    logic [6:0]    glifo;
    logic          paridadeOk;
    logic [1:0]    codCaixa, codRega;
    logic          caixaLegal, regaLegal;

    assign bordaDescida = linhaAnt & ~sinc2;
    assign EstadoFsm    = estado;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sinc1    <= 1'b1;
            sinc2    <= 1'b1;
            linhaAnt <= 1'b1;
        end else begin
            sinc1    <= LinhaSerial;
            sinc2    <= sinc1;
            linhaAnt <= sinc2;
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) estado <= IDLE;
        else        estado <= estadoProx;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        estadoProx = estado;
        zeraCnt    = 1'b0;
        amostra    = 1'b0;
        fimQuadro  = 1'b0;
        case (estado)
            IDLE: begin
                zeraCnt = 1'b1;
                if (bordaDescida || inicioPendente) estadoProx = START;
            end
            START: begin
                if (clkCnt == MEIO) begin
                    zeraCnt    = 1'b1;
                    estadoProx = sinc2 ? IDLE : DADOS;
                end
            end
            DADOS: begin
                if (clkCnt == FIM) begin
                    zeraCnt = 1'b1;
                    amostra = 1'b1;
                    if (bitIdx == 4'd8) estadoProx = STOP;
                end
            end
            STOP: begin
                if (clkCnt == FIM) begin
                    zeraCnt    = 1'b1;
                    fimQuadro  = 1'b1;
                    estadoProx = IDLE;
                end
            end
            default: estadoProx = IDLE;
        endcase
    end

    // Glyph reassembly ({a..g}, a is MSB), parity check and both decoders
    always_comb begin
        glifo      = {quadro[1], quadro[2], quadro[3], quadro[4], quadro[5], quadro[6], quadro[7]};
        paridadeOk = ~(^quadro);
        caixaLegal = 1'b1;
        codCaixa   = 2'd0;
        case (glifo)
            7'b1111110: codCaixa = 2'd0;
            7'b0110000: codCaixa = 2'd1;
            7'b1101101: codCaixa = 2'd2;
            7'b1111001: codCaixa = 2'd3;
            default:    caixaLegal = 1'b0;
        endcase
        regaLegal = 1'b1;
        codRega   = 2'd0;
        case (glifo)
            7'b0000001: codRega = 2'd0;
            7'b1011110: codRega = 2'd1;
            7'b1110111: codRega = 2'd2;
            7'b1001111: codRega = 2'd3;
            default:    regaLegal = 1'b0;
        endcase
    end

    // Bit timing, shift register and a start edge seen while still in STOP
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkCnt         <= '0;
            bitIdx         <= 4'd0;
            quadro         <= 9'd0;
            inicioPendente <= 1'b0;
        end else begin
            clkCnt <= zeraCnt ? '0 : clkCnt + 1'b1;
            if (estado == START) bitIdx <= 4'd0;
            else if (amostra)    bitIdx <= bitIdx + 4'd1;
            if (amostra) quadro <= {sinc2, quadro[8:1]};
            if (estado == STOP && bordaDescida) inicioPendente <= 1'b1;
            else if (estado == IDLE)            inicioPendente <= 1'b0;
        end
    end

    // Frame verdict and registered channel update at the stop-bit sample
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            SegCaixa     <= 7'd0;
            SegRega      <= 7'd0;
            NivelCaixa   <= 2'd0;
            NivelValido  <= 1'b0;
            TipoRega     <= 2'd0;
            RegaValido   <= 1'b0;
            QuadroOk     <= 1'b0;
            ErroParidade <= 1'b0;
            ErroQuadro   <= 1'b0;
        end else begin
            QuadroOk     <= 1'b0;
            ErroParidade <= 1'b0;
            ErroQuadro   <= 1'b0;
            if (fimQuadro) begin
                if (!sinc2) begin
                    ErroQuadro <= 1'b1;
                end else if (!paridadeOk) begin
                    ErroParidade <= 1'b1;
                end else begin
                    QuadroOk <= 1'b1;
                    if (!quadro[0]) begin
                        SegCaixa    <= glifo;
                        NivelValido <= caixaLegal;
                        if (caixaLegal) NivelCaixa <= codCaixa;
                    end else begin
                        SegRega    <= glifo;
                        RegaValido <= regaLegal;
                        if (regaLegal) TipoRega <= codRega;
                    end
                end
            end
        end
    end

endmodule
